fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the synchronous FIFO: pops one word at a time via rd_en/empty
//  and serialises it onto a UART line as start, LSB-first data, [parity], stop.

---
 rtl/fifo_uart_tx_if.sv | 33 +++
 rtl/fifo_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port and UART line status bundle for fifo_uart_tx.
// master: the drain stage; slave: the FIFO / pin side.
interface fifo_uart_tx_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  tx_enable;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;
   logic                  tx;
   logic                  busy;
   logic                  tx_done;

   modport master (
      input  tx_enable,
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en,
      output tx,
      output busy,
      output tx_done
   );

   modport slave (
      output tx_enable,
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en,
      input  tx,
      input  busy,
      input  tx_done
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time onto a UART line (start, LSB-first data, stop).
// Define UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_uart_tx_if.master bus
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IdxW = $clog2(DATA_WIDTH + STOP_BITS + 1);

   localparam logic [CntW-1:0] BaudLast   = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] BaudPenult = CntW'(CLKS_PER_BIT - 2);
   localparam logic [IdxW-1:0] DataLast   = IdxW'(DATA_WIDTH - 1);
   localparam logic [IdxW-1:0] StopLast   = IdxW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StData,
`ifdef UART_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e                state_q;
   logic [CntW-1:0]       baud_cnt_q;
   logic [IdxW-1:0]       bit_idx_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic                  tx_q;
   logic                  busy_q;
   logic                  rd_en_q;
   logic                  done_q;
`ifdef UART_PARITY_EN
   logic                  parity_q;
`endif

   logic baud_last;
   logic can_start;

   always_comb begin
      shift_nxt = shift_q >> 1;
      baud_last = (baud_cnt_q == BaudLast);
      can_start = bus.tx_enable && !bus.fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (can_start) begin
                  state_q <= StFetch;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StFetch: begin
               state_q <= StLoad;
            end
            // FIFO data is valid now, one cycle after the pop strobe.
            StLoad: begin
               shift_q    <= bus.fifo_data;
`ifdef UART_PARITY_EN
               parity_q   <= ^bus.fifo_data;
`endif
               tx_q       <= 1'b0;
               baud_cnt_q <= '0;
               state_q    <= StStart;
            end
            StStart: begin
               if (baud_last) begin
                  state_q    <= StData;
                  tx_q       <= shift_q[0];
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CntW'(1);
               end
            end
            StData: begin
               if (baud_last) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == DataLast) begin
                     bit_idx_q <= '0;
`ifdef UART_PARITY_EN
                     state_q   <= StParity;
                     tx_q      <= parity_q;
`else
                     state_q   <= StStop;
                     tx_q      <= 1'b1;
`endif
                  end else begin
                     shift_q   <= shift_nxt;
                     tx_q      <= shift_nxt[0];
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CntW'(1);
               end
            end
`ifdef UART_PARITY_EN
            StParity: begin
               if (baud_last) begin
                  state_q    <= StStop;
                  tx_q       <= 1'b1;
                  baud_cnt_q <= '0;
                  bit_idx_q  <= '0;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CntW'(1);
               end
            end
`endif
            StStop: begin
               // Raised one edge early so the registered pulse lands on the final cycle.
               if (bit_idx_q == StopLast && baud_cnt_q == BaudPenult) begin
                  done_q <= 1'b1;
               end
               if (baud_last) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == StopLast) begin
                     bit_idx_q <= '0;
                     if (can_start) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                     end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CntW'(1);
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.fifo_rd_en = rd_en_q;
   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx with a FIFO model and a frame-level reference model.
module tb_fifo_uart_tx;

   localparam int Cpb = 4;
   localparam int Dw  = 8;
   localparam int Sb  = 1;
`ifdef UART_PARITY_EN
   localparam int Pb = 1;
   localparam logic [15:0] ExpA5 = 16'h054A;
   localparam logic [15:0] Exp01 = 16'h0602;
   localparam logic [15:0] Exp3C = 16'h0478;
   localparam int FrameLen = 44;
`else
   localparam int Pb = 0;
   localparam logic [15:0] ExpA5 = 16'h034A;
   localparam logic [15:0] Exp01 = 16'h0202;
   localparam logic [15:0] Exp3C = 16'h0278;
   localparam int FrameLen = 40;
`endif
   localparam int Nb = 1 + Dw + Pb + Sb;
   localparam int Fl = 2 + Nb * Cpb;

   logic clk = 1'b0;
   logic rst_n;

   fifo_uart_tx_if #(.DATA_WIDTH(Dw)) bus ();

   fifo_uart_tx #(
      .CLKS_PER_BIT (Cpb),
      .DATA_WIDTH   (Dw),
      .STOP_BITS    (Sb)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int rd_cnt   = 0;
   int done_cnt = 0;
   int last_gap = -1;
   logic [7:0] fq[$];
   logic [7:0] mq[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      mq.push_back(w);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic frame_bit(input logic [7:0] w, input int k);
      if (k == 0) return 1'b0;
      if (k <= Dw) return w[k-1];
      if (Pb == 1 && k == Dw + 1) return ^w;
      return 1'b1;
   endfunction

   // FIFO: pops on the edge after a sampled rd_en; data and empty change just after that edge.
   bit pend;
   initial begin : fifo_model
      bus.fifo_empty = 1'b1;
      bus.fifo_data  = '0;
      forever begin
         @(negedge clk);
         pend = bus.fifo_rd_en;
         @(posedge clk);
         #1;
         if (pend && fq.size() > 0) bus.fifo_data = fq.pop_front();
         bus.fifo_empty = (fq.size() == 0);
      end
   end

   // Frame-level reference: a frame is Fl cycles starting at the pop cycle.
   bit         m_act = 1'b0;
   int         m_off = 0;
   logic [7:0] m_word = '0;
   int         cyc = 0;
   int         done_cyc = -100;
   logic       prev_tx = 1'b1;
   logic [3:0] got_v, exp_v;

   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_act)
            exp_v = {(m_off < 2) ? 1'b1 : frame_bit(m_word, (m_off - 2) / Cpb), 1'b1,
                     (m_off == 0), (m_off == Fl - 1)};
         else
            exp_v = 4'b1000;
         got_v = {bus.tx, bus.busy, bus.fifo_rd_en, bus.tx_done};
         check("tx/busy/rd_en/tx_done", 32'(got_v), 32'(exp_v));
         if (bus.fifo_rd_en) begin
            rd_cnt++;
            check("pop while empty", 32'(bus.fifo_empty), 32'd0);
         end
         if (bus.tx_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_tx && !bus.tx) last_gap = cyc - done_cyc - 1;
         prev_tx = bus.tx;
         if (!rst_n) begin
            m_act = 1'b0;
         end else if (m_act && m_off < Fl - 1) begin
            m_off++;
         end else if (bus.tx_enable && !bus.fifo_empty) begin
            m_act  = 1'b1;
            m_off  = 0;
            m_word = (mq.size() > 0) ? mq.pop_front() : 8'hxx;
         end else begin
            m_act = 1'b0;
         end
         cyc++;
      end
   end

   task automatic wait_rd(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = bus.fifo_rd_en;
      end
      check("rd_en within bound", 32'(seen), 32'd1);
   endtask

   task automatic capture_frame(output logic [15:0] cap, output int doff);
      bit seen;
      cap  = '0;
      doff = -1;
      wait_rd(seen);
      if (seen) begin
         for (int off = 1; off <= Fl - 1; off++) begin
            @(negedge clk);
            if (off >= 2 && (off - 2) % Cpb == Cpb / 2) cap[(off-2)/Cpb] = bus.tx;
            if (bus.tx_done) doff = off;
         end
      end
   endtask

   logic [15:0] cap;
   int doff, r0, d0;
   bit seen;

   initial begin : stim
      rst_n         = 1'b0;
      bus.tx_enable = 1'b1;
      push(8'hA5);

      repeat (3) begin
         @(negedge clk);
         check("reset tx", 32'(bus.tx), 32'd1);
         check("reset busy", 32'(bus.busy), 32'd0);
         check("reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
      end
      step(1);
      rst_n = 1'b1;

      r0 = rd_cnt;
      capture_frame(cap, doff);
      check("A5 frame bits", 32'(cap), 32'(ExpA5));
      check("A5 frame length", 32'(doff - 1), 32'(FrameLen));
      step(6);
      check("A5 pop count", 32'(rd_cnt - r0), 32'd1);

      push(8'h01);
      capture_frame(cap, doff);
      check("01 frame bits", 32'(cap), 32'(Exp01));
      step(6);

      r0 = rd_cnt;
      d0 = done_cnt;
      push(8'h00);
      push(8'hFF);
      for (int i = 0; i < 300 && (done_cnt - d0) < 2; i++) step(1);
      step(10);
      check("b2b pop count", 32'(rd_cnt - r0), 32'd2);
      check("b2b done count", 32'(done_cnt - d0), 32'd2);
      check("b2b mark gap", 32'(last_gap), 32'd2);
      check("b2b fifo empty", 32'(bus.fifo_empty), 32'd1);

      r0 = rd_cnt;
      d0 = done_cnt;
      push(8'h5A);
      push(8'hC3);
      wait_rd(seen);
      repeat (19) @(posedge clk);
      #2;
      bus.tx_enable = 1'b0;
      step(80);
      check("enable drop pops", 32'(rd_cnt - r0), 32'd1);
      check("enable drop done", 32'(done_cnt - d0), 32'd1);
      check("enable drop busy", 32'(bus.busy), 32'd0);
      check("enable drop left", 32'(fq.size()), 32'd1);

      push(8'h3C);
      bus.tx_enable = 1'b1;
      wait_rd(seen);
      repeat (27) @(posedge clk);
      #2;
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort tx", 32'(bus.tx), 32'd1);
      check("abort busy", 32'(bus.busy), 32'd0);
      capture_frame(cap, doff);
      check("3C frame bits", 32'(cap), 32'(Exp3C));
      check("3C frame length", 32'(doff - 1), 32'(FrameLen));

      for (int i = 0; i < 2500; i++) begin
         step(1);
         if ($urandom_range(0, 5) == 0 && fq.size() < 6) push(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 24) == 0) bus.tx_enable = ~bus.tx_enable;
         rst_n = ($urandom_range(0, 399) != 0);
      end

      rst_n         = 1'b1;
      bus.tx_enable = 1'b1;
      for (int i = 0; i < 3000 && (fq.size() > 0 || bus.busy); i++) step(1);
      step(5);
      check("drain fifo", 32'(fq.size()), 32'd0);
      check("drain model", 32'(mq.size()), 32'd0);
      check("drain busy", 32'(bus.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
